// File: rtl/m_dds_spi.sv
// m_dds_spi: DDS tone generator streaming saw/triangle/square/DC samples to a 3-wire SPI DAC
module m_dds_spi #(
    parameter int PHASE_W = 24,
    parameter int DAC_W = 12,
    parameter int FRAME_W = 16,
    parameter logic [FRAME_W-DAC_W-1:0] CTRL_WORD = '0,
    parameter int GAP = 4,
    parameter int CLK_DIV = 8,
    parameter logic [PHASE_W-1:0] FTW_INIT = 178957
) (
    input  logic               CLK30,
    input  logic               RST,
    input  logic [PHASE_W-1:0] FTW,
    input  logic               FTW_WE,
    input  logic               PHASE_RST,
    input  logic [1:0]         MODE,
    input  logic               ENABLE,
    output logic               SCLK,
    output logic               SDIN,
    output logic               SYNC,
    output logic               BUSY,
    output logic               FRAME_DONE
);
    localparam int SLOTS = GAP + FRAME_W;
    localparam int CW = $clog2(CLK_DIV);
    localparam int SW = $clog2(SLOTS);

    logic [CW-1:0]      div_cnt;
    logic [SW-1:0]      slot, slot_nx;
    logic               tick, rise, start, data_nx, en_frame;
    logic [PHASE_W-1:0] phase, ftw_act, ftw_pend, ftw_nx, p;
    logic               ftw_req, prst_req;
    logic [DAC_W-1:0]   t, wave;
    logic [FRAME_W-1:0] shift;

    // divider ticks, slot sequencing and the sample for the frame about to start
    always_comb begin
        tick = div_cnt == CW'(CLK_DIV - 1);
        rise = tick & ~SCLK;
        start = rise & (slot == SW'(SLOTS - 1));
        slot_nx = (slot == SW'(SLOTS - 1)) ? '0 : slot + SW'(1);
        data_nx = slot_nx >= SW'(GAP);
        ftw_nx = ftw_req ? ftw_pend : ftw_act;
        p = prst_req ? '0 : phase;
        t = p[PHASE_W-2 -: DAC_W];
        wave = (MODE == 2'd0) ? p[PHASE_W-1 -: DAC_W] :
               (MODE == 2'd1) ? (p[PHASE_W-1] ? ~t : t) :
               (MODE == 2'd2) ? {DAC_W{p[PHASE_W-1]}} :
               DAC_W'(1) << (DAC_W - 1);
        BUSY = ~SYNC;
    end

    // free-running SCLK: toggles every CLK_DIV cycles, never gated
    always_ff @(posedge CLK30) begin
        if (RST) begin
            div_cnt <= '0;
            SCLK <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + CW'(1);
            SCLK <= tick ? ~SCLK : SCLK;
        end
    end

    // host requests, slot counter and phase accumulator; requests arriving on the start edge survive it
    always_ff @(posedge CLK30) begin
        if (RST) begin
            slot <= SW'(SLOTS - 1);
            phase <= '0;
            ftw_act <= FTW_INIT;
            ftw_pend <= FTW_INIT;
            ftw_req <= 1'b0;
            prst_req <= 1'b0;
            en_frame <= 1'b0;
        end else begin
            ftw_pend <= FTW_WE ? FTW : ftw_pend;
            ftw_req <= FTW_WE | (ftw_req & ~start);
            prst_req <= PHASE_RST | (prst_req & ~start);
            if (rise)
                slot <= slot_nx;
            if (start) begin
                ftw_act <= ftw_nx;
                phase <= p + ftw_nx;
                en_frame <= ENABLE;
            end
        end
    end

    // serial outputs: load the word at frame start, emit MSB-first on each data-slot rise tick
    always_ff @(posedge CLK30) begin
        if (RST) begin
            SYNC <= 1'b1;
            SDIN <= 1'b0;
            FRAME_DONE <= 1'b0;
            shift <= '0;
        end else begin
            FRAME_DONE <= start & en_frame;
            if (rise && data_nx) begin
                SYNC <= ~en_frame;
                SDIN <= en_frame & shift[FRAME_W-1];
                shift <= shift << 1;
            end else if (rise) begin
                SYNC <= 1'b1;
                SDIN <= 1'b0;
                shift <= start ? {CTRL_WORD, wave} : shift;
            end
        end
    end
endmodule

// File: doc/m_dds_spi.md
# m_dds_spi

Parametrised DDS tone generator driving a serial-input DAC (AD5320-class, SYNC/SCLK/DIN) over a 3-wire SPI link. A phase accumulator advances once per DAC frame. The accumulated phase becomes a sawtooth, triangle, square or DC sample, which is shifted out MSB-first. The host can change the tuning word phase-continuously and can request a phase reset. The block is the next-generation signal-generator output stage of the scope, running directly on the 30 MHz system clock.

## Interface

- PHASE_W, 24: phase accumulator / tuning word width; must be ≥ DAC_W+1
- DAC_W, 12: DAC sample width
- FRAME_W, 16: data slots per frame with SYNC low; must be ≥ DAC_W
- CTRL_WORD, 4'b0000: the FRAME_W−DAC_W bits sent ahead of the sample (DAC control/power-down bits)
- GAP, 4: idle slots per frame with SYNC high; must be ≥ 1
- CLK_DIV, 8: CLK30 cycles per SCLK half-period; must be ≥ 2
- FTW_INIT, 178957: tuning word after reset (≈1 kHz at the defaults)

- CLK30 in 1: system clock, 30 MHz
- RST in 1: synchronous, active-high reset
- FTW in PHASE_W: tuning word
- FTW_WE in 1: one-cycle strobe that captures FTW into the pending register
- PHASE_RST in 1: one-cycle strobe that requests a phase-accumulator clear
- MODE in 2: waveform select; 0 saw, 1 triangle, 2 square, 3 DC midscale
- ENABLE in 1: frame enable, sampled at frame start
- SCLK out 1: serial clock
- SDIN out 1: serial data
- SYNC out 1: frame sync, active low
- BUSY out 1: high while SYNC is low
- FRAME_DONE out 1: one-cycle pulse at the end of each transmitted frame

## Operation

- Divider:
  - div_cnt counts 0..CLK_DIV−1; SCLK toggles on the edge where div_cnt = CLK_DIV−1.
  - The rise tick is the edge where SCLK goes 0→1.
  - SCLK runs freely with period 2·CLK_DIV; it is never gated.
- Slots:
  - The slot counter runs 0..GAP+FRAME_W−1 and advances on every rise tick, wrapping to 0.
  - Slots 0..GAP−1 are gap slots; slots GAP..GAP+FRAME_W−1 are data slots.
- Frame start: the rise tick that enters slot 0. At that edge, in this order:
  1. ftw_active ← pending FTW, if a write is outstanding.
  2. p ← 0 if a PHASE_RST request is outstanding, else phase.
  3. shift ← {CTRL_WORD, wave(p)}.
  4. phase ← p + ftw_active (the new value), modulo 2^PHASE_W.
  5. en_frame ← ENABLE; both outstanding requests are cleared.
- When en_frame = 0, steps 1–4 still take effect but nothing is sent: SYNC stays 1, SDIN 0, and no FRAME_DONE is issued.
- wave(p), with a = p[PHASE_W−1] and t = p[PHASE_W−2 −: DAC_W]:
  - saw = p[PHASE_W−1 −: DAC_W]
  - triangle = a ? ~t : t
  - square = a ? all ones : 0
  - DC = 1 << (DAC_W−1)
  - MODE is sampled at frame start.
- Data slots:
  - SYNC = 0 and SDIN = shift MSB, both registered on the rise tick that enters the slot.
  - shift moves left by one on each subsequent rise tick.
  - The DAC samples SDIN on the SCLK falling edge, CLK_DIV cycles after it changes.
- Gap slots: SYNC = 1, SDIN = 0.
- Requests:
  - FTW_WE overwrites the pending register; if several writes occur within one frame, the last one wins.
  - A FTW_WE or PHASE_RST arriving on the frame-start edge itself takes effect at the following frame start.
- FRAME_DONE pulses on the rise tick that ends the last data slot of an enabled frame. That edge is the same as the next frame start.
- BUSY = ~SYNC.

## Timing

- Reset values:
  - SCLK 0, SYNC 1, SDIN 0, BUSY 0, FRAME_DONE 0
  - phase 0, ftw_active FTW_INIT, no pending requests
  - div_cnt 0, slot counter at GAP+FRAME_W−1
- First frame start is at cycle CLK_DIV after RST deasserts.
- Slot length is 2·CLK_DIV cycles; frame period is 2·CLK_DIV·(GAP+FRAME_W) cycles (320 at the defaults). SYNC is low for 2·CLK_DIV·FRAME_W cycles (256).
- SCLK, SYNC and SDIN change on the same CLK30 edge.
- Tone frequency = ftw_active · 30 MHz / (2^PHASE_W · 2·CLK_DIV·(GAP+FRAME_W)).
- A FTW or PHASE_RST change is heard at the next frame start, a latency of at most one frame; the phase stays continuous across a FTW change.
- RST asserted mid-frame: every output takes its reset value on the next edge and the partial frame is abandoned. SYNC rising ends the DAC's frame without an update.

## Test plan

- Reset, defaults, MODE 0 → SYNC high for the first 64 cycles after the first frame start, then low for 256; frame period 320. Data words 0x0000, 0x002B, 0x0057.
- Write FTW 0x400000 with MODE 1 → samples 0x000, 0x800, 0xFFF, 0x7FF, repeating.
- Write FTW 0x800000 with MODE 2 → samples alternate 0x000, 0xFFF. MODE 3 → every sample is 0x800.
- Write FTW 0xFFFFFF after PHASE_RST, MODE 0 → samples 0x000, 0xFFF, 0xFFF (wrap-around is correct).
- FTW_WE in mid-frame and a second FTW_WE in the same frame → the current frame is unchanged and the next frame uses the second value. A PHASE_RST on the frame-start edge → the clear happens one frame later.
- ENABLE = 0 → SYNC stays 1 and no FRAME_DONE is issued. Assert RST mid-data → SYNC = 1 and SDIN = 0 on the next cycle, and a fresh frame starts CLK_DIV cycles after release.
